axis_spi_txn_ctrl: RTL and testbench
====================================

Name: axis_spi_txn_ctrl

Overview:
Transaction sequencer that sits directly upstream of axis_spi_master and consumes its response stream. It accepts one command word (slave address, write length, read length) plus a write-data byte stream. It issues write bytes and then dummy bytes to the master one at a time. Responses to write bytes are discarded; responses to dummy bytes are forwarded as a read packet terminated by tlast.

Parameters:
DATA_WIDTH, 8, byte width; equals axis_spi_master DATA_WIDTH
SLAVE_NUM, 1, number of chip selects; AW = max(1, $clog2(SLAVE_NUM))
LEN_WIDTH, 8, width of wr_len/rd_len; max length 2^LEN_WIDTH-1
DUMMY_BYTE, 8'hFF, MOSI value sent during read phase

Ports:
clk_i  in  1  system clock
arstn_i  in  1  reset; asynchronous, active-low
s_cmd_tdata  in  2*LEN_WIDTH+AW  [LEN_WIDTH-1:0]=rd_len, [2*LEN_WIDTH-1:LEN_WIDTH]=wr_len, top AW bits=addr
s_cmd_tvalid  in  1  command valid
s_cmd_tready  out  1  command ready
s_wr_tdata  in  DATA_WIDTH  write payload byte
s_wr_tvalid  in  1  payload valid
s_wr_tready  out  1  payload ready
m_spi_tdata  out  DATA_WIDTH  byte to master s_axis
m_spi_tvalid  out  1  valid to master
m_spi_tready  in  1  ready from master
s_spi_tdata  in  DATA_WIDTH  response byte from master m_axis
s_spi_tvalid  in  1  response valid
s_spi_tready  out  1  response ready
m_rd_tdata  out  DATA_WIDTH  read byte out
m_rd_tvalid  out  1  read valid
m_rd_tready  in  1  read ready
m_rd_tlast  out  1  last read byte of command
spi_addr_o  out  AW  slave select to master addr_i
busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, counters=0, spi_addr_o=0, busy_o=0. All tvalid/tready outputs are 0 except s_cmd_tready, which follows IDLE (1 once reset is released). Reset mid-transaction aborts immediately; no flush of partial payload.
- States: IDLE, SEND, WAIT_RSP.
- IDLE: s_cmd_tready=1.
  - On handshake: latch addr into spi_addr_o, latch wr_cnt=wr_len and rd_cnt=rd_len.
  - If both lengths are 0, consume the command and stay IDLE; no SPI traffic.
  - Otherwise go to SEND next cycle.
- Phase: write phase while wr_cnt!=0, else read phase.
- SEND, write phase: m_spi_tdata=s_wr_tdata, m_spi_tvalid=s_wr_tvalid, s_wr_tready=m_spi_tready (combinational pass-through).
- SEND, read phase: m_spi_tdata=DUMMY_BYTE, m_spi_tvalid=1, s_wr_tready=0.
- SEND exit: on m_spi handshake go to WAIT_RSP.
- Outstanding limit: exactly one byte outstanding; m_spi_tvalid=0 outside SEND.
- WAIT_RSP, write phase: s_spi_tready=1; response discarded; m_rd_tvalid=0. On handshake decrement wr_cnt.
- WAIT_RSP, read phase: m_rd_tdata=s_spi_tdata, m_rd_tvalid=s_spi_tvalid, s_spi_tready=m_rd_tready, m_rd_tlast=(rd_cnt==1). On handshake decrement rd_cnt.
- WAIT_RSP exit: after a response handshake, go to SEND if remaining wr_cnt+rd_cnt is nonzero, else IDLE.
- s_spi_tready=0 in IDLE and SEND; stray responses are held off, never dropped.
- spi_addr_o holds its value until the next command is accepted. It is stable for the whole transaction.
- Latency: cmd handshake at cycle N gives m_spi_tvalid at N+1 (read phase, or write phase with s_wr_tvalid high). Response-to-next-request latency: 1 cycle.
- m_rd_tlast never asserts when rd_len=0; the write-only command produces no m_rd beat.
- Counters are LEN_WIDTH bits and never wrap (decrement only when nonzero).

Test Plan:
1. Write only, master MISO looped to MOSI: cmd addr=0, wr=3, rd=0; payload A5,3C,0F -> m_spi sees A5,3C,0F in order; 3 responses consumed; zero m_rd beats; busy_o falls 1 cycle after the third response.
2. Read only, loopback: cmd wr=0, rd=2 -> m_spi sees FF,FF; m_rd gives FF (tlast=0), FF (tlast=1).
3. Mixed: wr=1 (9F), rd=3, slave model returning EF,40,18 for the dummies -> m_spi 9F,FF,FF,FF; m_rd EF,40,18 with tlast on 18; the 9F response is never on m_rd.
4. Zero-length: cmd wr=0, rd=0 -> s_cmd_tready stays 1, busy_o stays 0, no m_spi_tvalid.
5. Backpressure: rd=2, m_rd_tready low for 20 cycles -> s_spi_tready low for those 20 cycles; second FF not issued until first read beat is accepted; data intact.
6. Reset mid-op: assert arstn_i low during WAIT_RSP of wr=4 -> all outputs return to reset values in the same cycle; a new cmd rd=1 afterwards completes normally with tlast=1.

Source files
------------

// File: rtl/axis_spi_txn_ctrl.sv
// rtl/axis_spi_txn_ctrl.sv - SPI transaction sequencer: command + write payload in, read packet out
// Keeps exactly one byte outstanding at the SPI master; write-phase responses are dropped.
module axis_spi_txn_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int SLAVE_NUM  = 1,
  parameter int LEN_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] DUMMY_BYTE = 8'hFF,
  localparam int AW = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [2*LEN_WIDTH+AW-1:0]   s_cmd_tdata,
  input  logic                        s_cmd_tvalid,
  output logic                        s_cmd_tready,
  input  logic [DATA_WIDTH-1:0]       s_wr_tdata,
  input  logic                        s_wr_tvalid,
  output logic                        s_wr_tready,
  output logic [DATA_WIDTH-1:0]       m_spi_tdata,
  output logic                        m_spi_tvalid,
  input  logic                        m_spi_tready,
  input  logic [DATA_WIDTH-1:0]       s_spi_tdata,
  input  logic                        s_spi_tvalid,
  output logic                        s_spi_tready,
  output logic [DATA_WIDTH-1:0]       m_rd_tdata,
  output logic                        m_rd_tvalid,
  input  logic                        m_rd_tready,
  output logic                        m_rd_tlast,
  output logic [AW-1:0]               spi_addr_o,
  output logic                        busy_o
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_t;

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t               state;
  logic [LEN_WIDTH-1:0] wr_cnt;
  logic [LEN_WIDTH-1:0] rd_cnt;
  logic                 wr_phase;

  logic [LEN_WIDTH-1:0] cmd_rd;
  logic [LEN_WIDTH-1:0] cmd_wr;
  logic [AW-1:0]        cmd_addr;

  assign cmd_rd   = s_cmd_tdata[LEN_WIDTH-1:0];
  assign cmd_wr   = s_cmd_tdata[2*LEN_WIDTH-1:LEN_WIDTH];
  assign cmd_addr = s_cmd_tdata[2*LEN_WIDTH+AW-1:2*LEN_WIDTH];

  assign wr_phase = (wr_cnt != '0);
  assign busy_o   = (state != IDLE);

  // Gated by reset so the command port only opens once reset is released.
  assign s_cmd_tready = arstn_i && (state == IDLE);

  always_comb begin
    m_spi_tdata  = DUMMY_BYTE;
    m_spi_tvalid = 1'b0;
    s_wr_tready  = 1'b0;
    s_spi_tready = 1'b0;
    m_rd_tdata   = '0;
    m_rd_tvalid  = 1'b0;
    m_rd_tlast   = 1'b0;
    case (state)
      SEND: begin
        if (wr_phase) begin
          m_spi_tdata  = s_wr_tdata;
          m_spi_tvalid = s_wr_tvalid;
          s_wr_tready  = m_spi_tready;
        end else begin
          m_spi_tvalid = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (wr_phase) begin
          s_spi_tready = 1'b1;
        end else begin
          m_rd_tdata   = s_spi_tdata;
          m_rd_tvalid  = s_spi_tvalid;
          s_spi_tready = m_rd_tready;
          m_rd_tlast   = (rd_cnt == ONE);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      spi_addr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_cmd_tvalid) begin
            spi_addr_o <= cmd_addr;
            wr_cnt     <= cmd_wr;
            rd_cnt     <= cmd_rd;
            if (cmd_wr != '0 || cmd_rd != '0) state <= SEND;
          end
        end
        SEND: begin
          if (m_spi_tvalid && m_spi_tready) state <= WAIT_RSP;
        end
        WAIT_RSP: begin
          if (s_spi_tvalid && s_spi_tready) begin
            // Next state looks at what remains after this decrement.
            if (wr_phase) begin
              wr_cnt <= wr_cnt - ONE;
              state  <= (wr_cnt != ONE || rd_cnt != '0) ? SEND : IDLE;
            end else if (rd_cnt != '0) begin
              rd_cnt <= rd_cnt - ONE;
              state  <= (rd_cnt != ONE) ? SEND : IDLE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_spi_txn_ctrl.sv
// tb/tb_axis_spi_txn_ctrl.sv - randomized scoreboard bench for axis_spi_txn_ctrl
// A slave model answers each SPI byte; each command is scored against its payload and responses.
module tb_axis_spi_txn_ctrl;

  localparam int AW = 2;

  logic              clk_i;
  logic              arstn_i;
  logic [17:0]       s_cmd_tdata;
  logic              s_cmd_tvalid;
  logic              s_cmd_tready;
  logic [7:0]        s_wr_tdata;
  logic              s_wr_tvalid;
  logic              s_wr_tready;
  logic [7:0]        m_spi_tdata;
  logic              m_spi_tvalid;
  logic              m_spi_tready;
  logic [7:0]        s_spi_tdata;
  logic              s_spi_tvalid;
  logic              s_spi_tready;
  logic [7:0]        m_rd_tdata;
  logic              m_rd_tvalid;
  logic              m_rd_tready;
  logic              m_rd_tlast;
  logic [AW-1:0]     spi_addr_o;
  logic              busy_o;

  axis_spi_txn_ctrl #(
    .DATA_WIDTH(8), .SLAVE_NUM(4), .LEN_WIDTH(8), .DUMMY_BYTE(8'hFF)
  ) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
    .s_wr_tdata(s_wr_tdata), .s_wr_tvalid(s_wr_tvalid), .s_wr_tready(s_wr_tready),
    .m_spi_tdata(m_spi_tdata), .m_spi_tvalid(m_spi_tvalid), .m_spi_tready(m_spi_tready),
    .s_spi_tdata(s_spi_tdata), .s_spi_tvalid(s_spi_tvalid), .s_spi_tready(s_spi_tready),
    .m_rd_tdata(m_rd_tdata), .m_rd_tvalid(m_rd_tvalid), .m_rd_tready(m_rd_tready),
    .m_rd_tlast(m_rd_tlast), .spi_addr_o(spi_addr_o), .busy_o(busy_o)
  );

  int tests = 0;
  int errors = 0;

  logic [7:0] wr_q[$];
  logic [7:0] got_spi[$];
  logic [7:0] got_rd[$];
  bit         got_last[$];
  logic [7:0] rsp_log[$];
  logic [7:0] rsp_script[$];

  logic [AW-1:0] cur_addr = '0;
  int  cur_wr = 0;
  int  cur_total = 0;
  int  rsp_cnt = 0;
  bit  pending = 0;
  int  delay = 0;
  logic [7:0] rsp_byte = '0;
  bit  loopback = 1;
  bit  sink_block = 0;
  bit  abort = 0;
  bit  chk_busy_next = 0;
  bit  exp_busy = 0;

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SPI slave: one response per accepted byte, after a random delay.
  initial begin
    m_spi_tready = 0;
    s_spi_tvalid = 0;
    s_spi_tdata  = '0;
    forever begin
      @(negedge clk_i);
      m_spi_tready = ($urandom_range(0, 3) != 0);
      if (pending && delay == 0) begin
        s_spi_tvalid = 1;
        s_spi_tdata  = rsp_byte;
      end else begin
        s_spi_tvalid = 0;
        s_spi_tdata  = 8'($urandom);
        if (pending) delay--;
      end
      #1;
      if (chk_busy_next && arstn_i) begin
        check("busy_after_rsp", busy_o, exp_busy);
        if (exp_busy && rsp_cnt >= cur_wr) check("rsp_to_req_lat", m_spi_tvalid, 1);
      end
      chk_busy_next = 0;
      #3;
      if (arstn_i) begin
        if (s_spi_tvalid && s_spi_tready) begin
          pending = 0;
          rsp_cnt++;
          chk_busy_next = 1;
          exp_busy = (rsp_cnt < cur_total);
        end
        if (m_spi_tvalid && m_spi_tready) begin
          check("one_outstanding", pending, 0);
          check("spi_addr_stable", spi_addr_o, cur_addr);
          got_spi.push_back(m_spi_tdata);
          if (rsp_script.size() > 0) rsp_byte = rsp_script.pop_front();
          else if (loopback) rsp_byte = m_spi_tdata;
          else rsp_byte = 8'($urandom);
          rsp_log.push_back(rsp_byte);
          pending = 1;
          delay = $urandom_range(0, 2);
        end
      end
    end
  end

  // Read sink with random or forced backpressure.
  initial begin
    m_rd_tready = 0;
    forever begin
      @(negedge clk_i);
      m_rd_tready = sink_block ? 1'b0 : ($urandom_range(0, 3) != 0);
      #4;
      if (arstn_i && m_rd_tvalid && m_rd_tready) begin
        got_rd.push_back(m_rd_tdata);
        got_last.push_back(m_rd_tlast);
      end
    end
  end

  task automatic drive_payload();
    int i = 0;
    int gap = $urandom_range(0, 2);
    while (i < wr_q.size() && !abort) begin
      @(negedge clk_i);
      if (abort) break;
      if (gap > 0) begin
        s_wr_tvalid = 0;
        gap--;
      end else begin
        s_wr_tvalid = 1;
        s_wr_tdata  = wr_q[i];
        #4;
        if (s_wr_tready) begin
          i++;
          gap = $urandom_range(0, 2);
        end
      end
    end
    if (!abort) @(negedge clk_i);
    s_wr_tvalid = 0;
  endtask

  task automatic start_cmd(input logic [AW-1:0] addr, input logic [7:0] wr, input logic [7:0] rd);
    int n = 0;
    got_spi.delete(); got_rd.delete(); got_last.delete(); rsp_log.delete();
    cur_addr = addr; cur_wr = int'(wr); cur_total = int'(wr) + int'(rd); rsp_cnt = 0;
    @(negedge clk_i);
    s_cmd_tdata  = {addr, wr, rd};
    s_cmd_tvalid = 1;
    fork drive_payload(); join_none
    forever begin
      #4;
      if (s_cmd_tready) break;
      n++;
      if (n > 100) begin check("cmd_accept_timeout", 1, 0); break; end
      @(negedge clk_i);
    end
    @(negedge clk_i);
    s_cmd_tvalid = 0;
    s_cmd_tdata  = 18'($urandom);
    #1;
    check("busy_after_cmd", busy_o, (wr != 0 || rd != 0));
    check("addr_latched", spi_addr_o, addr);
    if (wr == 0 && rd != 0) check("cmd_to_req_lat", m_spi_tvalid, 1);
  endtask

  task automatic wait_done(input int wr, input int rd);
    int n = 0;
    while (!(got_spi.size() == wr + rd && got_rd.size() == rd && !busy_o && !pending)) begin
      @(negedge clk_i);
      #2;
      n++;
      if (n > 500) begin check("done_timeout", 0, 1); break; end
    end
  endtask

  task automatic verify(input int wr, input int rd);
    check("spi_count", got_spi.size(), wr + rd);
    for (int i = 0; i < got_spi.size() && i < wr + rd; i++)
      check("spi_byte", got_spi[i], (i < wr) ? wr_q[i] : 8'hFF);
    check("rd_count", got_rd.size(), rd);
    for (int i = 0; i < got_rd.size() && i < rd; i++) begin
      if (wr + i < rsp_log.size()) check("rd_byte", got_rd[i], rsp_log[wr + i]);
      else check("rd_byte_no_rsp", 0, 1);
      check("rd_last", got_last[i], (i == rd - 1));
    end
  endtask

  task automatic reset_checks();
    check("rst_busy", busy_o, 0);
    check("rst_m_spi_tvalid", m_spi_tvalid, 0);
    check("rst_s_wr_tready", s_wr_tready, 0);
    check("rst_s_spi_tready", s_spi_tready, 0);
    check("rst_m_rd_tvalid", m_rd_tvalid, 0);
    check("rst_m_rd_tlast", m_rd_tlast, 0);
    check("rst_spi_addr", spi_addr_o, 0);
    check("rst_s_cmd_tready", s_cmd_tready, 0);
  endtask

  initial begin
    logic [7:0] exp3[3];
    int wr, rd;
    arstn_i = 0;
    s_cmd_tdata = '0; s_cmd_tvalid = 0;
    s_wr_tdata = '0; s_wr_tvalid = 0;
    repeat (3) @(negedge clk_i);
    #1 reset_checks();
    @(negedge clk_i);
    #2 arstn_i = 1;
    #1 check("cmd_ready_after_rst", s_cmd_tready, 1);

    // write only, loopback
    loopback = 1;
    wr_q = '{8'hA5, 8'h3C, 8'h0F};
    start_cmd(2'd0, 8'd3, 8'd0);
    wait_done(3, 0);
    verify(3, 0);

    // read only, loopback
    wr_q = {};
    start_cmd(2'd1, 8'd0, 8'd2);
    wait_done(0, 2);
    verify(0, 2);

    // mixed with scripted slave responses
    rsp_script = '{8'h77, 8'hEF, 8'h40, 8'h18};
    wr_q = '{8'h9F};
    start_cmd(2'd2, 8'd1, 8'd3);
    wait_done(1, 3);
    verify(1, 3);
    exp3 = '{8'hEF, 8'h40, 8'h18};
    for (int i = 0; i < 3 && i < got_rd.size(); i++) check("mixed_rd_const", got_rd[i], exp3[i]);

    // zero-length command
    wr_q = {};
    start_cmd(2'd3, 8'd0, 8'd0);
    repeat (4) begin
      @(negedge clk_i);
      #1;
      check("zero_no_spi", m_spi_tvalid, 0);
      check("zero_cmd_ready", s_cmd_tready, 1);
      check("zero_busy", busy_o, 0);
    end
    verify(0, 0);

    // read backpressure
    sink_block = 1;
    start_cmd(2'd1, 8'd0, 8'd2);
    begin
      int n = 0;
      @(negedge clk_i);
      #2;
      while (!m_rd_tvalid && n < 50) begin
        @(negedge clk_i);
        #2;
        n++;
      end
      check("bp_rd_valid_seen", m_rd_tvalid, 1);
    end
    repeat (20) begin
      check("bp_spi_ready_low", s_spi_tready, 0);
      check("bp_no_second_req", m_spi_tvalid, 0);
      @(negedge clk_i);
      #2;
    end
    sink_block = 0;
    wait_done(0, 2);
    verify(0, 2);

    // reset during write-phase response wait
    wr_q = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    start_cmd(2'd2, 8'd4, 8'd0);
    begin
      int n = 0;
      while (!s_spi_tready && n < 100) begin
        @(negedge clk_i);
        #2;
        n++;
      end
      check("rst_mid_wait_seen", s_spi_tready, 1);
    end
    arstn_i = 0;
    abort = 1;
    pending = 0;
    chk_busy_next = 0;
    s_wr_tvalid = 0;
    s_spi_tvalid = 0;
    rsp_script.delete();
    #1 reset_checks();
    repeat (2) @(negedge clk_i);
    #2 arstn_i = 1;
    abort = 0;
    wr_q = {};
    start_cmd(2'd3, 8'd0, 8'd1);
    wait_done(0, 1);
    verify(0, 1);

    // randomized commands
    repeat (25) begin
      wr = $urandom_range(0, 5);
      rd = $urandom_range(0, 5);
      loopback = $urandom_range(0, 1);
      wr_q = {};
      for (int i = 0; i < wr; i++) wr_q.push_back(8'($urandom));
      start_cmd(AW'($urandom), 8'(wr), 8'(rd));
      wait_done(wr, rd);
      verify(wr, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
